// File: rtl/serial_comparator.sv
// Serial loader / comparator: shifts two operands in digit-serially, then streams out
// the larger or smaller one LSB-first. Optional macro: SERIAL_COMPARATOR_RECIRC_EN (non-destructive readout).
module serial_comparator #(
    parameter int DIGIT_W    = 2,
    parameter int NUM_DIGITS = 4
) (
    input  logic               CLK,
    input  logic               RSTL,
    input  logic [DIGIT_W-1:0] D_IN,
    input  logic               D_EN,
    input  logic               SWITCH,
    input  logic               COMPARE_MODE,
    input  logic               COMPARE_EN,
    input  logic               SEL_MIN,
    output logic [DIGIT_W-1:0] D_OUT,
    output logic               D_VALID,
    output logic               BUSY,
    output logic               A_GT_B,
    output logic               A_EQ_B
);

    localparam int W     = DIGIT_W * NUM_DIGITS;
    localparam int CNT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_DIGITS - 1);

    typedef enum logic {S_IDLE, S_OUT} state_t;

    // Handshake: D_EN loads a digit only while BUSY=0; COMPARE_EN starts a burst only
    // while BUSY=0 with COMPARE_MODE=1. While BUSY=1, D_VALID=1 marks every D_OUT digit;
    // there is no back-pressure, the burst runs NUM_DIGITS cycles unless aborted.
    state_t           r_state;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sel_a;
    logic             r_gt;
    logic             r_eq;

    logic [W-1:0]     w_a_shift;
    logic [W-1:0]     w_b_shift;
    logic             w_a_gt_b;
    logic             w_a_eq_b;

    assign w_a_gt_b = (r_a > r_b);
    assign w_a_eq_b = (r_a == r_b);

`ifdef SERIAL_COMPARATOR_RECIRC_EN
    assign w_a_shift = {r_a[DIGIT_W-1:0], r_a[W-1:DIGIT_W]};
    assign w_b_shift = {r_b[DIGIT_W-1:0], r_b[W-1:DIGIT_W]};
`else
    assign w_a_shift = {{DIGIT_W{1'b0}}, r_a[W-1:DIGIT_W]};
    assign w_b_shift = {{DIGIT_W{1'b0}}, r_b[W-1:DIGIT_W]};
`endif

    always_ff @(posedge CLK) begin
        if (!RSTL) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_cnt   <= '0;
            r_sel_a <= 1'b0;
            r_gt    <= 1'b0;
            r_eq    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (D_EN) begin
                        if (SWITCH) r_b <= {D_IN, r_b[W-1:DIGIT_W]};
                        else        r_a <= {D_IN, r_a[W-1:DIGIT_W]};
                    end
                    // Compare uses the register contents before any same-edge load.
                    if (COMPARE_MODE && COMPARE_EN) begin
                        r_state <= S_OUT;
                        r_cnt   <= '0;
                        r_gt    <= w_a_gt_b;
                        r_eq    <= w_a_eq_b;
                        r_sel_a <= (w_a_gt_b ^ SEL_MIN) | w_a_eq_b;
                    end
                end
                S_OUT: begin
                    if (!COMPARE_MODE) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_a <= w_a_shift;
                        r_b <= w_b_shift;
                        if (r_cnt == LAST_CNT) begin
                            r_state <= S_IDLE;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        D_OUT = '0;
        if (!COMPARE_MODE)         D_OUT = D_IN;
        else if (r_state == S_OUT) D_OUT = r_sel_a ? r_a[DIGIT_W-1:0] : r_b[DIGIT_W-1:0];
    end

    assign BUSY    = (r_state == S_OUT);
    assign D_VALID = BUSY;
    assign A_GT_B  = r_gt;
    assign A_EQ_B  = r_eq;

endmodule
